// File: rtl/gpr_pkg.sv
// Shared register-file definitions for the writeback path.
// GPR_RVE_EN selects a 16-entry RV32E file; otherwise the file has 32 entries.
package gpr_pkg;

   localparam int DATAWIDTH_DEF = 32;
   localparam int ADDRWIDTH_DEF = 5;

`ifdef GPR_RVE_EN
   localparam int GPR_NUM = 16;
`else
   localparam int GPR_NUM = 32;
`endif

   typedef struct packed {
      logic [ADDRWIDTH_DEF-1:0] rd;
      logic [DATAWIDTH_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// In-order pending-write FIFO with an age-ordered view (index 0 = oldest) for bypass.
// Write visible in the view one cycle after push; caller must not push when full unless popping.
module gpr_wb_fifo
   import gpr_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  entry_t                 push_dat,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic [DEPTH-1:0]       view_vld,
   output entry_t                 view_dat [DEPTH]
);

   localparam int PW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= push_dat;
            wptr      <= wptr + 1'b1;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         view_dat[k] = mem[rptr + PW'(k)];
         view_vld[k] = int'(count) > k;
      end
   end

endmodule

// File: rtl/gpr_wb.sv
// Writeback FIFO + GPR array with bypassing read ports; retire pulse one cycle after pop.
// wb_ready drops when full unless the head retires this cycle; GPR_RVE_EN drops writes/reads to x16..x31.
module gpr_wb
   import gpr_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ADDRWIDTH = ADDRWIDTH_DEF,
   parameter int DEPTH     = 2
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wb_valid,
   output logic                   wb_ready,
   input  logic [ADDRWIDTH-1:0]   wb_rd,
   input  logic [DATAWIDTH-1:0]   wb_data,
   input  logic                   commit_en,
   input  logic [ADDRWIDTH-1:0]   raddr1,
   input  logic [ADDRWIDTH-1:0]   raddr2,
   output logic [DATAWIDTH-1:0]   rdata1,
   output logic [DATAWIDTH-1:0]   rdata2,
   output logic [$clog2(DEPTH):0] pending,
   output logic                   retire_valid,
   output logic [ADDRWIDTH-1:0]   retire_rd
);

   typedef struct packed {
      logic [ADDRWIDTH-1:0] rd;
      logic [DATAWIDTH-1:0] data;
   } entry_t;

   localparam int GW = $clog2(GPR_NUM);

   function automatic logic in_file(input logic [ADDRWIDTH-1:0] a);
      return int'(a) < GPR_NUM;
   endfunction

   logic [DATAWIDTH-1:0] regs [GPR_NUM];
   entry_t               push_dat;
   entry_t               head;
   entry_t               view_dat [DEPTH];
   logic [DEPTH-1:0]     view_vld;
   logic                 push;
   logic                 pop;

   assign pop      = commit_en && (pending != '0);
   assign wb_ready = rst_n && ((int'(pending) < DEPTH) || pop);
   assign push     = wb_valid && wb_ready;
   assign push_dat = '{rd: wb_rd, data: wb_data};
   assign head     = view_dat[0];

   gpr_wb_fifo #(
      .DEPTH    (DEPTH),
      .entry_t  (entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .count    (pending),
      .view_vld (view_vld),
      .view_dat (view_dat)
   );

   // x0 and out-of-file indices are popped but never written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < GPR_NUM; i++)
            regs[i] <= '0;
      end else if (pop && (head.rd != '0) && in_file(head.rd)) begin
         regs[GW'(head.rd)] <= head.data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_valid <= 1'b0;
         retire_rd    <= '0;
      end else begin
         retire_valid <= pop;
         retire_rd    <= pop ? head.rd : '0;
      end
   end

   logic [ADDRWIDTH-1:0] raddr [2];
   logic [DATAWIDTH-1:0] rdata [2];

   assign raddr[0] = raddr1;
   assign raddr[1] = raddr2;
   assign rdata1   = rdata[0];
   assign rdata2   = rdata[1];

   // Ascending age scan: the youngest matching pending entry overrides older ones.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         if ((raddr[p] != '0) && in_file(raddr[p])) begin
            rdata[p] = regs[GW'(raddr[p])];
            for (int k = 0; k < DEPTH; k++)
               if (view_vld[k] && (view_dat[k].rd == raddr[p]))
                  rdata[p] = view_dat[k].data;
         end
      end
   end

endmodule

// File: tb/tb_gpr_wb.sv
// Randomized and directed checks of gpr_wb against a queue-based model of the register file.
module tb_gpr_wb;

   localparam int DEPTH = 2;
`ifdef GPR_RVE_EN
   localparam int NREG = 16;
`else
   localparam int NREG = 32;
`endif

   logic        clk;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        commit_en;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [1:0]  pending;
   logic        retire_valid;
   logic [4:0]  retire_rd;

   gpr_wb #(.DATAWIDTH(32), .ADDRWIDTH(5), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .commit_en    (commit_en),
      .raddr1       (raddr1),
      .raddr2       (raddr2),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .pending      (pending),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes as a queue (front = oldest), plus a plain register array.
   typedef struct { int rd; logic [31:0] data; } ent_t;
   ent_t        q[$];
   logic [31:0] m_regs [32];
   logic [31:0] ret_log[$];
   bit          exp_rv;
   int          exp_rrd;
   bit          m_pop;
   bit          m_push;
   bit          chk_en = 0;

   function automatic bit m_ready();
      if (!rst_n) return 0;
      if (q.size() < DEPTH) return 1;
      return commit_en;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      if (a == 0 || a >= NREG) return 32'h0;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].rd == a) return q[i].data;
      return m_regs[a];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         exp_rv  = 0;
         exp_rrd = 0;
      end else begin
         m_push = wb_valid && m_ready();
         m_pop  = commit_en && (q.size() > 0);
         exp_rv = m_pop;
         if (m_pop) begin
            ent_t h;
            h = q.pop_front();
            if (h.rd != 0 && h.rd < NREG) m_regs[h.rd] = h.data;
            exp_rrd = h.rd;
            ret_log.push_back(h.data);
         end
         if (m_push) q.push_back('{int'(wb_rd), wb_data});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("wb_ready", {31'h0, wb_ready}, {31'h0, m_ready()});
         check("pending", {30'h0, pending}, q.size());
         check("rdata1", rdata1, m_read(int'(raddr1)));
         check("rdata2", rdata2, m_read(int'(raddr2)));
         check("retire_valid", {31'h0, retire_valid}, {31'h0, exp_rv});
         if (exp_rv) check("retire_rd", {27'h0, retire_rd}, exp_rrd);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [4:0] rd, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_rd    = rd;
      wb_data  = d;
      cyc();
      wb_valid = 1'b0;
   endtask

   initial begin
      rst_n = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
      commit_en = 0; raddr1 = 0; raddr2 = 0;
      cyc();
      chk_en = 1;
      cyc();
      raddr1 = 5;
      #2;
      check("rst_pending", {30'h0, pending}, 32'd0);
      check("rst_ready", {31'h0, wb_ready}, 32'd0);
      check("rst_retire", {31'h0, retire_valid}, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);

      // 1: single write, bypass then retire
      rst_n = 1; commit_en = 1;
      push_one(5'd5, 32'h12345678);
      #2;
      check("t1_pending", {30'h0, pending}, 32'd1);
      check("t1_bypass", rdata1, 32'h12345678);
      cyc();
      check("t1_rv", {31'h0, retire_valid}, 32'd1);
      check("t1_rrd", {27'h0, retire_rd}, 32'd5);
      check("t1_array", rdata1, 32'h12345678);
      check("t1_pending0", {30'h0, pending}, 32'd0);

      // 2: youngest pending write to the same register wins
      commit_en = 0; raddr2 = 3;
      push_one(5'd3, 32'h1);
      push_one(5'd3, 32'h2);
      #2;
      check("t2_pending", {30'h0, pending}, 32'd2);
      check("t2_ready", {31'h0, wb_ready}, 32'd0);
      check("t2_young", rdata2, 32'h2);
      ret_log.delete();
      commit_en = 1;
      cyc();
      check("t2_rrd", {27'h0, retire_rd}, 32'd3);
      cyc(); cyc();
      check("t2_nret", ret_log.size(), 32'd2);
      if (ret_log.size() == 2) begin
         check("t2_ord0", ret_log[0], 32'h1);
         check("t2_ord1", ret_log[1], 32'h2);
      end
      check("t2_final", rdata2, 32'h2);

      // 3: x0 write is popped but never stored
      raddr1 = 0;
      push_one(5'd0, 32'hFFFFFFFF);
      #2;
      check("t3_rdata0", rdata1, 32'd0);
      cyc();
      check("t3_rv", {31'h0, retire_valid}, 32'd1);
      check("t3_rrd", {27'h0, retire_rd}, 32'd0);
      check("t3_rdata0b", rdata1, 32'd0);

      // 4: full FIFO with push+pop every cycle
      commit_en = 0;
      push_one(5'd1, 32'h1001);
      push_one(5'd2, 32'h1002);
      ret_log.delete();
      commit_en = 1;
      for (int i = 3; i <= 10; i++) begin
         wb_valid = 1; wb_rd = 5'(i); wb_data = 32'h1000 + i;
         #2;
         check("t4_ready", {31'h0, wb_ready}, 32'd1);
         check("t4_pending", {30'h0, pending}, 32'd2);
         cyc();
      end
      wb_valid = 0;
      repeat (3) cyc();
      check("t4_nret", ret_log.size(), 32'd10);
      for (int i = 0; i < ret_log.size() && i < 10; i++)
         check("t4_order", ret_log[i], 32'h1001 + i);

      // 5: reset discards pending writes and clears the array
      commit_en = 0;
      push_one(5'd7, 32'h77);
      push_one(5'd8, 32'h88);
      rst_n = 0;
      #2;
      check("t5_ready", {31'h0, wb_ready}, 32'd0);
      cyc();
      rst_n = 1; commit_en = 1; raddr1 = 7; raddr2 = 5;
      #2;
      check("t5_pending", {30'h0, pending}, 32'd0);
      check("t5_r7", rdata1, 32'd0);
      check("t5_r5", rdata2, 32'd0);
      cyc();
      check("t5_norv", {31'h0, retire_valid}, 32'd0);
      cyc();
      check("t5_norv2", {31'h0, retire_valid}, 32'd0);

`ifdef GPR_RVE_EN
      // 6: indices 16..31 are dropped and never aliased onto x0..x15
      raddr1 = 17;
      push_one(5'd17, 32'hA5);
      #2;
      check("t6_r17", rdata1, 32'd0);
      cyc();
      check("t6_rv", {31'h0, retire_valid}, 32'd1);
      check("t6_rrd", {27'h0, retire_rd}, 32'd17);
      raddr1 = 1;
      #2;
      check("t6_r1", rdata1, 32'd0);
`endif

      // Randomized traffic, narrow index range to exercise bypass hits
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 249) != 0);
         wb_valid  = ($urandom_range(0, 2) != 0);
         wb_rd     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         wb_data   = $urandom;
         commit_en = ($urandom_range(0, 4) < 3);
         raddr1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         raddr2    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         cyc();
      end

      rst_n = 1; wb_valid = 0; commit_en = 1;
      repeat (4) cyc();
      chk_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
